// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - operand/result handshake bundle for serial_adder_ctrl; ovf present with SERIAL_ADDER_OVF_EN
interface serial_adder_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (output start, a_in, b_in, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a_in, b_in, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a_in, b_in, cin, input busy, done, sum, cout);
    modport slave  (input start, a_in, b_in, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder, LSB first; SERIAL_ADDER_OVF_EN adds signed overflow output
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                clk,
    input logic                rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   sum_sr_q, sum_sr_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic bit_s;
    logic bit_c;
    logic last_bit;

    // one full-adder slice on the current LSB pair and the held carry
    assign bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign bit_c    = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

    // next-state: load on start, one bit per RUN cycle, single DONE cycle
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a_in;
                    b_sr_d   = bus.b_in;
                    carry_d  = bus.cin;
                    cnt_d    = '0;
                    sum_sr_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                sum_sr_d = {bit_s, sum_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = bit_c;
                if (last_bit) begin
                    // counter parks at WIDTH-1; results publish only here
                    sum_d   = sum_sr_d;
                    cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
                    ovf_d   = carry_q ^ bit_c;
`endif
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf  = ovf_q;
`endif

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial N-bit adder that sits directly upstream of the single-bit full adder. It loads two operands and a carry-in, then feeds one bit pair per clock, LSB first, into a 1-bit sum/carry slice. The carry is held in a register between slices. Each sum bit is shifted into a result register, and completion is signalled with a one-cycle `done` pulse. Throughput is one addition per WIDTH+1 cycles plus the start cycle, which trades area for latency against a ripple-carry array.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥2)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A, captured on accepted start
- b_in  input  WIDTH  operand B, captured on accepted start
- cin  input  1  carry-in, captured on accepted start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result, held until next accepted start
- cout  output  1  final carry-out, held with sum
- ovf  output  1  signed overflow (present only with SERIAL_ADDER_OVF_EN)

## Operation
- One clock, `clk`. Reset is synchronous and active-high on `rst`. Reset has priority over all other inputs.
- Reset values:
  - state=IDLE
  - busy=0, done=0
  - sum=0, cout=0, ovf=0
  - internal shift registers, carry register and bit counter all 0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - On start=1, load A_sr←a_in, B_sr←b_in, carry←cin, cnt←0, sum_sr←0.
  - Go to RUN.
  - start=0 stays in IDLE. sum and cout keep their last values.
- RUN, every cycle:
  - s = A_sr[0]^B_sr[0]^carry.
  - c = (A_sr[0]&B_sr[0]) | (carry&(A_sr[0]^B_sr[0])).
  - sum_sr ← {s, sum_sr[WIDTH-1:1]}.
  - A_sr and B_sr shift right with zero fill.
  - carry←c; cnt←cnt+1.
  - When cnt==WIDTH-1 (last bit): sum←{s, sum_sr[WIDTH-1:1]}, cout←c, go to DONE.
- DONE: done=1 for this cycle only, then unconditionally go to IDLE. start is ignored in DONE.
- start is ignored whenever busy=1. No queuing and no error flag.
- Arithmetic: {cout,sum} = a_in + b_in + cin, computed modulo 2^(WIDTH+1).
- cnt is ceil(log2(WIDTH)) bits wide and never wraps past WIDTH-1.
- Reset asserted during RUN or DONE aborts the operation: partial sum is discarded, outputs return to reset values, and no done pulse is produced.
- start held high continuously produces back-to-back additions. A new start is accepted in the IDLE cycle following DONE.

## Timing
- Accepted start at rising edge k.
- RUN spans edges k+1 … k+WIDTH, one bit per edge.
- DONE is entered at edge k+WIDTH, so done is high during the cycle between edges k+WIDTH and k+WIDTH+1.
- Latency from start accept to done: WIDTH cycles. Minimum issue interval: WIDTH+2 cycles.
- sum and cout update only at edge k+WIDTH. They are stable and valid whenever done=1 and remain unchanged until the next accepted start.
- busy rises at edge k and falls at edge k+WIDTH+1.
- All outputs are registered; no combinational path from input to output.

## Configuration
- Macro SERIAL_ADDER_OVF_EN.
- Defined:
  - Port `ovf` exists.
  - On the last RUN cycle, ovf ← carry ^ c (carry into MSB XOR carry out of MSB), i.e. two's-complement overflow.
  - Updated and held alongside sum. Reset value 0.
- Undefined: port `ovf` and its logic are absent. All other behaviour is identical.

## Test plan
- Reset then idle: assert rst for 2 cycles → busy=0, done=0, sum=0, cout=0. With start=0 for 20 cycles, outputs are unchanged.
- Basic add, WIDTH=8: a_in=8'h35, b_in=8'h4A, cin=0, start at edge k → done only in cycle k+8, sum=8'h7F, cout=0. With the macro, ovf=0.
- Carry chain: a_in=8'hFF, b_in=8'h00, cin=1 → sum=8'h00, cout=1. Then a_in=8'h7F, b_in=8'h01, cin=0 → sum=8'h80, cout=0, ovf=1 (macro on).
- Busy rejection: during RUN, pulse start with a_in=8'h11, b_in=8'h22 → these operands are ignored and the result reflects the first operands.
- Back-to-back: start held high with 3 operand pairs presented at each accepted start → 3 done pulses spaced 10 cycles apart, each with the correct sum.
- Reset mid-operation: assert rst at RUN bit 4 → next cycle busy=0, sum=0, no done pulse. A fresh start after reset completes normally.
